// File: rtl/seed_expand_gen.sv
// WOTS seed expander: derives seed_i = PRF(key, idx_base + i) for a run-time count of seeds
// through the shared sha256XMSS core, writing them to seed memory or streaming them out.
module seed_expand_gen #(
  parameter int SEED_NUM              = 67,
  parameter int KEY_LEN               = 256,
  parameter int XMSS_HASH_PADDING_PRF = 3,
  parameter int AW                    = $clog2(SEED_NUM),
  parameter int CW                    = $clog2(SEED_NUM + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [KEY_LEN-1:0] input_key,
  input  logic [31:0]        idx_base,
  input  logic [CW-1:0]      seed_count,
  output logic               busy,
  output logic               done,
  output logic               hash_start,
  output logic [1023:0]      hash_data_in,
  output logic               message_length,
  input  logic               hash_done,
  input  logic [KEY_LEN-1:0] hash_data_out,
  output logic [KEY_LEN-1:0] seed_wr_data,
  output logic [AW-1:0]      seed_mem_wr_addr,
  output logic               seed_mem_wr_en,
  output logic               seed_valid,
  input  logic               seed_ready,
  output logic [AW-1:0]      seed_index
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EMIT   = 3'd3,
    ST_FIN    = 3'd4,
    ST_DRAIN  = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic [KEY_LEN-1:0] key_r, seed_r, msg_key_s;
  logic [31:0]        base_r, msg_idx_s;
  logic [CW-1:0]      count_r, n_s, idx_next_s;
  logic [AW-1:0]      idx_r;
  logic               mode_r, busy_r, done_r, hash_start_r, wr_en_r, valid_r;
  logic               emit_fire_s, more_s;
  logic [1023:0]      msg_r, msg_s;

  // Run length clamp, emit handshake and the PRF message for the next launch
  always_comb begin
    n_s         = seed_count;
    idx_next_s  = CW'(idx_r) + CW'(1'b1);
    more_s      = (idx_next_s < count_r);
    emit_fire_s = (state_r == ST_EMIT) && !abort && (!mode_r || seed_ready);
    msg_key_s   = key_r;
    msg_idx_s   = base_r + 32'(idx_next_s);
    if (seed_count > CW'(SEED_NUM)) begin
      n_s = CW'(SEED_NUM);
    end else begin
      n_s = seed_count;
    end
    // The first launch comes straight from IDLE, before key/base are latched
    if (state_r == ST_IDLE) begin
      msg_key_s = input_key;
      msg_idx_s = idx_base;
    end else begin
      msg_key_s = key_r;
      msg_idx_s = base_r + 32'(idx_next_s);
    end
    msg_s = {256'(XMSS_HASH_PADDING_PRF), msg_key_s, 224'd0, msg_idx_s, 256'd0};
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = (n_s == CW'(1'b0)) ? ST_FIN : ST_LAUNCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LAUNCH: state_s = abort ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (abort) begin
          state_s = hash_done ? ST_IDLE : ST_DRAIN;
        end else if (hash_done) begin
          state_s = ST_EMIT;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_EMIT: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (emit_fire_s) begin
          state_s = more_s ? ST_LAUNCH : ST_FIN;
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_FIN:   state_s = ST_IDLE;
      ST_DRAIN: state_s = hash_done ? ST_IDLE : ST_DRAIN;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State, latched run parameters, datapath and registered output flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      key_r        <= '0;
      base_r       <= 32'd0;
      count_r      <= '0;
      mode_r       <= 1'b0;
      idx_r        <= '0;
      seed_r       <= '0;
      msg_r        <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      hash_start_r <= 1'b0;
      wr_en_r      <= 1'b0;
      valid_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      busy_r       <= (state_s != ST_IDLE) && (state_s != ST_FIN);
      done_r       <= (state_s == ST_FIN);
      hash_start_r <= (state_s == ST_LAUNCH);
      wr_en_r      <= (state_s == ST_EMIT) && !mode_r;
      valid_r      <= (state_s == ST_EMIT) && mode_r;
      if ((state_r == ST_IDLE) && start) begin
        key_r   <= input_key;
        base_r  <= idx_base;
        count_r <= n_s;
        mode_r  <= mode;
        idx_r   <= '0;
      end
      if (state_s == ST_LAUNCH) begin
        msg_r <= msg_s;
      end
      if ((state_r == ST_WAIT) && hash_done && !abort) begin
        seed_r <= hash_data_out;
      end
      if (emit_fire_s && more_s) begin
        idx_r <= AW'(idx_next_s);
      end
    end
  end

  // A same-cycle abort must suppress the write or handshake of the seed being emitted
  assign seed_mem_wr_en   = wr_en_r & ~abort;
  assign seed_valid       = valid_r & ~abort;
  assign busy             = busy_r;
  assign done             = done_r;
  assign hash_start       = hash_start_r;
  assign hash_data_in     = msg_r;
  assign message_length   = 1'b1;
  assign seed_wr_data     = seed_r;
  assign seed_mem_wr_addr = idx_r;
  assign seed_index       = idx_r;

endmodule

// File: tb/tb_seed_expand_gen.sv
// Self-checking bench for seed_expand_gen: a behavioural hash-core stand-in, a stream sink and
// a scoreboard that rebuilds every expected PRF message and seed from the run parameters.
module tb_seed_expand_gen;
  localparam int SEED_NUM = 67;
  localparam int KEY_LEN  = 256;
  localparam int AW       = $clog2(SEED_NUM);
  localparam int CW       = $clog2(SEED_NUM + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset = 1'b1, start = 1'b0, abort = 1'b0, mode = 1'b0;
  logic [KEY_LEN-1:0] input_key = '0;
  logic [31:0]        idx_base = 32'd0;
  logic [CW-1:0]      seed_count = '0;
  logic               busy, done, hash_start, message_length, seed_mem_wr_en, seed_valid;
  logic [1023:0]      hash_data_in;
  logic               hash_done = 1'b0, seed_ready = 1'b1;
  logic [KEY_LEN-1:0] hash_data_out = '0, seed_wr_data;
  logic [AW-1:0]      seed_mem_wr_addr, seed_index;

  seed_expand_gen #(.SEED_NUM(SEED_NUM), .KEY_LEN(KEY_LEN), .XMSS_HASH_PADDING_PRF(3)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .input_key(input_key), .idx_base(idx_base), .seed_count(seed_count),
    .busy(busy), .done(done), .hash_start(hash_start), .hash_data_in(hash_data_in),
    .message_length(message_length), .hash_done(hash_done), .hash_data_out(hash_data_out),
    .seed_wr_data(seed_wr_data), .seed_mem_wr_addr(seed_mem_wr_addr),
    .seed_mem_wr_en(seed_mem_wr_en), .seed_valid(seed_valid), .seed_ready(seed_ready),
    .seed_index(seed_index)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // PRF message as the software builds it: pad(3) | key | idx zero-extended | zeros
  function automatic logic [1023:0] ref_msg(input logic [255:0] k, input logic [31:0] idx);
    logic [255:0] pad, fld;
    pad = 256'd3;
    fld = 256'(idx);
    return {pad, k, fld, 256'd0};
  endfunction

  // Stand-in for sha256XMSS: any deterministic mix of key, index and padding will do
  function automatic logic [255:0] mock_hash(input logic [1023:0] m);
    logic [31:0] w;
    w = (m[287:256] * 32'h9E37_79B9) ^ m[799:768] ^ 32'(m[1023:1000]);
    return m[767:512] ^ {8{w}} ^ {m[255:0]};
  endfunction

  logic [1023:0] q_msg[$];
  logic [AW-1:0] q_waddr[$], q_sidx[$];
  logic [255:0]  q_wdata[$], q_sdata[$];
  int            done_cnt = 0, launch_cnt = 0, stall_cycles = 0;
  int            rdy_policy = 0, stall_left = 0, lat_min = 1, lat_max = 4, hcnt = 0;
  logic          prev_stall = 1'b0;
  logic [255:0]  prev_data = '0;
  logic [AW-1:0] prev_idx = '0;
  logic [1023:0] hmsg = '0;

  // Sink, monitor and hash-core model, all acting mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      hcnt       = 0;
      hash_done  = 1'b0;
      seed_ready = 1'b1;
      prev_stall = 1'b0;
    end else begin
      if (rdy_policy == 1) seed_ready = ($urandom_range(0, 3) != 0);
      else if (rdy_policy == 2 && seed_valid && seed_index == AW'(2) && stall_left > 0) begin
        seed_ready = 1'b0;
        stall_left--;
      end else seed_ready = 1'b1;
      if (prev_stall) begin
        check("stall_valid", 256'(seed_valid), 256'(1));
        check("stall_data", seed_wr_data, prev_data);
        check("stall_idx", 256'(seed_index), 256'(prev_idx));
      end
      prev_stall = seed_valid && !seed_ready;
      prev_data  = seed_wr_data;
      prev_idx   = seed_index;
      if (seed_valid && seed_ready) begin q_sidx.push_back(seed_index); q_sdata.push_back(seed_wr_data); end
      if (seed_valid && !seed_ready) stall_cycles++;
      if (seed_mem_wr_en) begin q_waddr.push_back(seed_mem_wr_addr); q_wdata.push_back(seed_wr_data); end
      if (done) begin
        done_cnt++;
        check("busy_at_done", 256'(busy), 256'(0));
      end
      if (hash_done) hash_done = 1'b0;
      if (hcnt > 0) begin
        check("msg_stable", 256'(hash_data_in == hmsg), 256'(1));
        hcnt--;
        if (hcnt == 0) begin
          hash_done     = 1'b1;
          hash_data_out = mock_hash(hmsg);
        end
      end
      if (hash_start) begin
        launch_cnt++;
        q_msg.push_back(hash_data_in);
        hmsg = hash_data_in;
        hcnt = $urandom_range(lat_min, lat_max);
      end
    end
  end

  task automatic clear_sb();
    q_msg.delete(); q_waddr.delete(); q_wdata.delete(); q_sidx.delete(); q_sdata.delete();
    done_cnt = 0; launch_cnt = 0; stall_cycles = 0;
  endtask

  // One run: start at T, follow it to done (or the abort drain), then score it
  task automatic run_seq(input logic [255:0] k, input logic [31:0] b, input int cnt, input logic md,
                         input int pol, input int abort_at, input int extra_start_at, input int exp_stall);
    int n, nexp, nl, ab_cyc, cyc;
    logic aborted, finished;
    logic [1023:0] em;
    n = (cnt > SEED_NUM) ? SEED_NUM : cnt;
    clear_sb();
    rdy_policy = pol; stall_left = 3; aborted = 1'b0; finished = 1'b0; ab_cyc = 0;
    @(posedge clk); #1;
    start = 1'b1; mode = md; input_key = k; idx_base = b; seed_count = CW'(cnt);
    @(posedge clk); #1;
    start = 1'b0; mode = ~md; input_key = ~k; idx_base = $urandom; seed_count = CW'($urandom_range(0, 127));
    check("busy_T1", 256'(busy), 256'(n > 0));
    check("hstart_T1", 256'(hash_start), 256'(n > 0));
    check("done_T1", 256'(done), 256'(n == 0));
    for (cyc = 0; cyc < 20000; cyc++) begin
      if (abort_at < 0 && done) begin finished = 1'b1; break; end
      if (aborted && !busy) begin finished = 1'b1; break; end
      if (abort_at >= 0 && !aborted && launch_cnt == abort_at + 1) begin
        abort = 1'b1; aborted = 1'b1; ab_cyc = cyc;
      end
      if (cyc == extra_start_at) start = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
    end
    check("run_timeout", 256'(finished), 256'(1));
    if (aborted) check("drain_len", 256'(cyc - ab_cyc), 256'(lat_max));
    @(posedge clk); #1;
    check("done_pulse", 256'(done), 256'(0));
    check("busy_after", 256'(busy), 256'(0));
    check("done_cnt", 256'(done_cnt), 256'(abort_at < 0 ? 1 : 0));
    nexp = (abort_at < 0) ? n : abort_at;
    nl   = (abort_at < 0) ? n : abort_at + 1;
    check("n_launch", 256'(q_msg.size()), 256'(nl));
    for (int j = 0; j < q_msg.size() && j < nl; j++) begin
      em = ref_msg(k, b + 32'(j));
      for (int c = 0; c < 4; c++) check("hash_msg", q_msg[j][c*256 +: 256], em[c*256 +: 256]);
    end
    check("n_writes", 256'(q_waddr.size()), 256'(md ? 0 : nexp));
    check("n_stream", 256'(q_sidx.size()), 256'(md ? nexp : 0));
    for (int j = 0; j < q_waddr.size() && j < nexp; j++) begin
      check("wr_addr", 256'(q_waddr[j]), 256'(j));
      check("wr_data", q_wdata[j], mock_hash(ref_msg(k, b + 32'(j))));
    end
    for (int j = 0; j < q_sidx.size() && j < nexp; j++) begin
      check("s_index", 256'(q_sidx[j]), 256'(j));
      check("s_data", q_sdata[j], mock_hash(ref_msg(k, b + 32'(j))));
    end
    if (exp_stall >= 0) check("stall_cycles", 256'(stall_cycles), 256'(exp_stall));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 256'(busy), 256'(0));
    check({tag, "_done"}, 256'(done), 256'(0));
    check({tag, "_hstart"}, 256'(hash_start), 256'(0));
    check({tag, "_wren"}, 256'(seed_mem_wr_en), 256'(0));
    check({tag, "_valid"}, 256'(seed_valid), 256'(0));
    check({tag, "_wdata"}, seed_wr_data, 256'd0);
    check({tag, "_addr"}, 256'(seed_mem_wr_addr), 256'(0));
    check({tag, "_sidx"}, 256'(seed_index), 256'(0));
    check({tag, "_msg_hi"}, hash_data_in[1023:512], 256'd0);
    check({tag, "_msg_lo"}, hash_data_in[511:256], 256'd0);
    check({tag, "_msglen"}, 256'(message_length), 256'(1));
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[j*32 +: 32] = $urandom;
    return k;
  endfunction

  initial begin
    logic [255:0] key0;
    int wait_cyc;
    key0 = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    reset = 1'b0;

    run_seq(key0, 32'd0, SEED_NUM, 1'b0, 0, -1, -1, -1);
    run_seq(rand_key(), 32'd10, 5, 1'b1, 2, -1, 8, 3);
    run_seq(rand_key(), $urandom, 0, 1'b0, 0, -1, -1, -1);
    run_seq(rand_key(), $urandom, SEED_NUM + 9, 1'b1, 1, -1, -1, -1);
    run_seq(rand_key(), 32'hFFFF_FFFE, 3, 1'b0, 0, -1, -1, -1);

    lat_min = 4; lat_max = 4;
    run_seq(key0, 32'd100, 6, 1'b0, 0, 3, -1, -1);
    run_seq(key0, 32'd100, 6, 1'b0, 0, -1, -1, -1);
    lat_min = 1;

    clear_sb();
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; input_key = key0; idx_base = 32'd7; seed_count = CW'(10);
    @(posedge clk); #1;
    start = 1'b0;
    wait_cyc = 0;
    while (launch_cnt < 2 && wait_cyc < 1000) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check("rst_reach_wait", 256'(launch_cnt), 256'(2));
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("midrst");
    reset = 1'b0;
    run_seq(key0, 32'd7, 10, 1'b0, 0, -1, -1, -1);

    for (int r = 0; r < 6; r++) begin
      run_seq(rand_key(), $urandom, $urandom_range(0, SEED_NUM + 9), 1'($urandom_range(0, 1)),
              $urandom_range(0, 1), -1, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
